// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I hazard controller: forwarding-select
// encodings, the x0 register index and the multiply-occupancy FSM states.
package riscv_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_t;

  // Forwarding select for one EX source operand; M beats W, x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic       wr_m,
                                         input logic [4:0] rd_m,
                                         input logic       wr_w,
                                         input logic [4:0] rd_w,
                                         input logic [4:0] rs);
    logic [1:0] sel;
    sel = FWD_RF;
    if (wr_m && (rd_m != REG_ZERO) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (wr_w && (rd_w != REG_ZERO) && (rd_w == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mul_occupancy.sv
// Multiply occupancy of the EX stage: a two-state FSM with a down-counter.
// A start loads MUL_LAT; the counter runs down regardless of memory stalls,
// but the FSM only releases EX (MulDoneE pulse) once memory is not stalling.
import riscv_pkg::*;

module mul_occupancy #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4   // 2**CNT_W must exceed MUL_LAT
) (
  input  logic clk,
  input  logic rst,           // asynchronous, active-low
  input  logic mul_start,
  input  logic mem_stall,
  output logic mul_stall,
  output logic mul_done
);

  mul_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  // State and counter registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, counter update and stall/done decode.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mul_stall  = 1'b0;
    mul_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (mul_start && !mem_stall) begin
          state_next = MUL_BUSY;
          cnt_next   = CNT_W'(MUL_LAT);
          mul_stall  = 1'b1;
        end
      end
      MUL_BUSY: begin
        if (cnt != '0) begin
          cnt_next  = cnt - 1'b1;
          mul_stall = 1'b1;
        end else if (!mem_stall) begin
          state_next = IDLE;
          mul_done   = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: stall enables,
// D/E flushes and EX forwarding selects, all combinational, plus the
// multiply-occupancy FSM in mul_occupancy.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating StallCycles and
// FlushCount performance counters.
// While rst is low every output is forced to 0 immediately.
import riscv_pkg::*;

module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       LoadE,
  input  logic       PCSrcE,
  input  logic       MulStartE,
  input  logic       DMemReqM,
  input  logic       DMemReadyM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MulDoneE
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
`endif
);

  logic mem_stall, mul_stall, lw_stall, mul_done;
  logic stall_e_raw, stall_d_raw;

  assign mem_stall = DMemReqM && !DMemReadyM;
  assign lw_stall  = LoadE && (RdE != REG_ZERO) && ((RdE == Rs1D) || (RdE == Rs2D));

  mul_occupancy #(
    .MUL_LAT (MUL_LAT),
    .CNT_W   (CNT_W)
  ) u_mul_occupancy (
    .clk       (clk),
    .rst       (rst),
    .mul_start (MulStartE),
    .mem_stall (mem_stall),
    .mul_stall (mul_stall),
    .mul_done  (mul_done)
  );

  assign stall_e_raw = mem_stall || mul_stall;
  assign stall_d_raw = stall_e_raw || lw_stall;

  // Output decode; everything is held at 0 while reset is asserted.
  always_comb begin
    StallM    = rst && mem_stall;
    StallE    = rst && stall_e_raw;
    StallD    = rst && stall_d_raw;
    StallF    = rst && stall_d_raw;
    // A taken branch under an EX stall waits: PCSrcE stays up until EX frees.
    FlushE    = rst && !stall_e_raw && (lw_stall || PCSrcE);
    FlushD    = rst && ((!stall_d_raw && PCSrcE) || (PCSrcE && !stall_e_raw));
    ForwardAE = rst ? fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs1E) : FWD_RF;
    ForwardBE = rst ? fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs2E) : FWD_RF;
    MulDoneE  = rst && mul_done;
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating counters of stalled-fetch cycles and EX flushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (StallF && (StallCycles != 32'hFFFF_FFFF)) StallCycles <= StallCycles + 32'd1;
      if (FlushE && (FlushCount != 32'hFFFF_FFFF)) FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MUL_LAT=4, default build).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, LoadE, PCSrcE, MulStartE, DMemReqM, DMemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, MulDoneE;
  logic [1:0] ForwardAE, ForwardBE;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.MUL_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE),
    .PCSrcE(PCSrcE), .MulStartE(MulStartE),
    .DMemReqM(DMemReqM), .DMemReadyM(DMemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MulDoneE(MulDoneE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pack the seven 1-bit outputs: {StallF,StallD,StallE,StallM,FlushD,FlushE,MulDoneE}
  function automatic logic [31:0] ctl();
    return {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, MulDoneE};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0; MulStartE = 0;
    DMemReqM = 0; DMemReadyM = 0;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    // Hazards present during reset must not show on outputs
    LoadE = 1; RdE = 5; Rs1D = 5; RegWriteM = 1; RdM = 7; Rs1E = 7;
    DMemReqM = 1; PCSrcE = 1;
    #3;
    chk("reset_ctl", ctl(), 32'h0);
    chk("reset_fwdA", {30'd0, ForwardAE}, 32'h0);
    next_cycle();
    rst = 1'b1;
    clear_inputs();
    #1;
    chk("idle_ctl", ctl(), 32'h0);

    // Load-use on rs1: StallF/D=1, StallE=0, FlushE=1
    next_cycle();
    LoadE = 1; RdE = 5; Rs1D = 5; #1;
    chk("lw_rs1_ctl", ctl(), 32'b1100010);
    Rs1D = 0; Rs2D = 9; RdE = 9; #1;
    chk("lw_rs2_ctl", ctl(), 32'b1100010);
    RdE = 0; Rs1D = 0; Rs2D = 0; #1;
    chk("lw_x0_ctl", ctl(), 32'h0);
    LoadE = 0;

    // Taken branch without stall flushes D and E
    PCSrcE = 1; #1;
    chk("branch_ctl", ctl(), 32'b0000110);
    PCSrcE = 0;

    // Forwarding priority
    RegWriteM = 1; RegWriteW = 1; RdM = 7; RdW = 7; Rs1E = 7; Rs2E = 3; #1;
    chk("fwdA_M", {30'd0, ForwardAE}, 32'd2);
    chk("fwdB_none", {30'd0, ForwardBE}, 32'd0);
    RdM = 0; #1;
    chk("fwdA_W", {30'd0, ForwardAE}, 32'd1);
    RdM = 3; #1;
    chk("fwdB_M", {30'd0, ForwardBE}, 32'd2);
    RegWriteM = 0; #1;
    chk("fwdB_noWrM", {30'd0, ForwardBE}, 32'd0);
    RdW = 0; Rs1E = 0; RegWriteM = 1; RdM = 0; #1;
    chk("fwdA_x0", {30'd0, ForwardAE}, 32'd0);
    clear_inputs();

    // Multiply: StallE t..t+4, MulDoneE at t+5 only
    next_cycle();
    MulStartE = 1; #1;
    chk("mul_t0", ctl(), 32'b1110000);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      chk($sformatf("mul_t%0d", k), ctl(), 32'b1110000);
    end
    next_cycle();
    chk("mul_done", ctl(), 32'b0000001);
    next_cycle();
    MulStartE = 0; #1;
    chk("mul_after", ctl(), 32'h0);

    // Memory wait across multiply completion
    next_cycle();
    MulStartE = 1; #1;
    chk("mw_t0", ctl(), 32'b1110000);
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      chk($sformatf("mw_t%0d", k), ctl(), 32'b1110000);
    end
    for (int k = 4; k <= 6; k++) begin
      next_cycle();
      DMemReqM = 1; DMemReadyM = 0; #1;
      chk($sformatf("mw_t%0d", k), ctl(), 32'b1111000);
    end
    next_cycle();
    DMemReqM = 0; #1;
    chk("mw_done", ctl(), 32'b0000001);
    next_cycle();
    MulStartE = 0; #1;
    chk("mw_after", ctl(), 32'h0);

    // Taken branch held under a multiply stall
    next_cycle();
    MulStartE = 1; PCSrcE = 1; #1;
    chk("br_mul_t0", ctl(), 32'b1110000);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      chk($sformatf("br_mul_t%0d", k), ctl(), 32'b1110000);
    end
    next_cycle();
    chk("br_mul_done", ctl(), 32'b0000111);
    next_cycle();
    MulStartE = 0; PCSrcE = 0; #1;
    chk("br_mul_after", ctl(), 32'h0);

    // Reset asserted mid-multiply with cnt=2
    next_cycle();
    MulStartE = 1; #1;
    next_cycle();  // cnt=4
    next_cycle();  // cnt=3
    next_cycle();  // cnt=2
    chk("rm_busy", ctl(), 32'b1110000);
    RegWriteM = 1; RdM = 4; Rs1E = 4; #1;
    rst = 1'b0; #1;
    chk("rm_ctl", ctl(), 32'h0);
    chk("rm_fwdA", {30'd0, ForwardAE}, 32'h0);
    next_cycle();
    rst = 1'b1; MulStartE = 0; RegWriteM = 0; #1;
    chk("rm_release", ctl(), 32'h0);
    next_cycle();
    chk("rm_idle", ctl(), 32'h0);
    MulStartE = 1; #1;
    chk("rm_restart", ctl(), 32'b1110000);
    MulStartE = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core. It produces the StallF/StallD/StallE/StallM enables consumed by the PC and pipeline registers, and the FlushD/FlushE clears.
- It also produces the EX-stage forwarding selects.
- Sequential part: tracks multi-cycle multiply occupancy of EX with a down-counter FSM, and overlays data-memory wait-state stalls.

Parameters:
- MUL_LAT, 4, EX-stage stall cycles for a multiply (legal range 2..16)
- CNT_W, 4, counter width; must satisfy 2^CNT_W > MUL_LAT

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous, active-low reset
- Rs1D  input  5  rs1 of instruction in Decode
- Rs2D  input  5  rs2 of instruction in Decode
- Rs1E  input  5  rs1 of instruction in Execute
- Rs2E  input  5  rs2 of instruction in Execute
- RdE  input  5  rd of instruction in Execute
- RdM  input  5  rd in Memory stage
- RdW  input  5  rd in Writeback stage
- RegWriteM  input  1  Memory-stage instruction writes rd
- RegWriteW  input  1  Writeback-stage instruction writes rd
- LoadE  input  1  Execute-stage instruction is a load
- PCSrcE  input  1  branch taken / jump in Execute
- MulStartE  input  1  Execute-stage instruction is a multiply
- DMemReqM  input  1  data-memory access in Memory stage
- DMemReadyM  input  1  data memory completes access this cycle
- StallF, StallD, StallE, StallM  output  1 each  hold the corresponding pipeline register
- FlushD, FlushE  output  1 each  synchronous clear of the D/E registers
- ForwardAE, ForwardBE  output  2 each  00 = register file, 10 = ALU result from M, 01 = result from W
- MulDoneE  output  1  multiply result valid in Execute this cycle

Behaviour:
- Reset: rst low → state IDLE, cnt=0. While rst is low, all outputs are forced to 0, asynchronously and immediately, including mid-multiply.
- FSM states:
  - IDLE, MUL_BUSY.
  - IDLE → MUL_BUSY when MulStartE && !memStall; load cnt=MUL_LAT.
  - MUL_BUSY: cnt decrements by 1 per cycle while cnt != 0, regardless of memStall.
  - MUL_BUSY → IDLE when cnt==0 && !memStall.
- memStall = DMemReqM && !DMemReadyM. This is combinational, not a state.
- mulStall = (IDLE && MulStartE && !memStall) || (MUL_BUSY && cnt != 0).
- MulDoneE = MUL_BUSY && cnt==0 && !memStall. It is a single-cycle pulse, and the multiply instruction leaves EX at the end of that cycle.
- Multiply timing: start in cycle t → StallE high in cycles t..t+MUL_LAT, MulDoneE in cycle t+MUL_LAT+1.
- MulStartE while in MUL_BUSY is ignored; the same instruction is still held in EX.
- lwStall = LoadE && RdE != 0 && (RdE==Rs1D || RdE==Rs2D).
- Stall outputs, priority memStall > mulStall > lwStall:
  - StallM = memStall.
  - StallE = memStall || mulStall.
  - StallF = StallD = StallE || lwStall.
- Flush outputs:
  - FlushE = !StallE && (lwStall || PCSrcE).
  - FlushD = !StallD && PCSrcE, or PCSrcE && !StallE.
  - A taken branch under an EX stall is deferred, because PCSrcE is held until EX releases.
- Forwarding, combinational, shown for A (B is identical with Rs2E):
  - 10 if RegWriteM && RdM != 0 && RdM==Rs1E;
  - else 01 if RegWriteW && RdW != 0 && RdW==Rs1E;
  - else 00.
  - x0 is never forwarded; M wins over W.
- All stall, flush and forward outputs are combinational from inputs and state, with zero latency.

Optional Feature:
- HAZARD_PERF_CNT_EN: adds outputs StallCycles[31:0] and FlushCount[31:0].
  - StallCycles increments each cycle StallF=1.
  - FlushCount increments each cycle FlushE=1.
  - Both saturate at 32'hFFFFFFFF and are cleared by rst.
- Without the macro these ports and registers are absent, with identical core behaviour.

Decomposition:
- Shared package riscv_pkg: forwarding-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10; the FSM state typedef; the REG_ZERO=5'd0 constant.
- One sub-module, mul_occupancy: the FSM plus counter, producing mulStall and MulDoneE. Forwarding and stall logic stay in the top level.

Test Plan:
- Reset mid-multiply: rst low while cnt=2 → all outputs 0 immediately; after release, state IDLE and StallE=0 with MulStartE=0.
- Load-use: LoadE=1, RdE=5, Rs1D=5 → StallF=StallD=1, FlushE=1, StallE=0. With RdE=0 → no stall.
- Forward priority: RegWriteM=RegWriteW=1, RdM=RdW=Rs1E=7 → ForwardAE=10. With RdM=0 → 01. With Rs2E=3 unmatched → ForwardBE=00.
- Multiply, MUL_LAT=4: MulStartE held from t → StallE high t..t+4, MulDoneE at t+5 only, StallE low at t+5.
- Memory wait during multiply completion: DMemReadyM=0 from t+4..t+6 → MulDoneE withheld until t+7, no restart of the multiply, StallM=1 for t+4..t+6.
- Branch under stall: PCSrcE=1 during mulStall → FlushD=FlushE=0 until the MulDoneE cycle, then both 1 for one cycle.
